mem_io_responder: RTL

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Memory and I/O responder: REM/RDM registers, 256x8 memory, buffered IN port and
// OUT register with sticky overflow/underflow flags. Every strobe takes effect on the next edge.
module mem_io_responder (
    input  logic       clk,
    input  logic       rst,
    input  logic       writeREM,
    input  logic       selectREM,
    input  logic       writeRDM,
    input  logic [1:0] selectRDM,
    input  logic       writeMEM,
    input  logic       writeOUT,
    input  logic [7:0] pc,
    input  logic [7:0] ac,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] rem_q,
    output logic [7:0] rdm_q,
    output logic [7:0] mem_q,
    output logic       out_ovf,
    output logic       in_unf
);

    localparam logic [1:0] SRC_AC   = 2'b00;
    localparam logic [1:0] SRC_IN   = 2'b01;
    localparam logic [1:0] SRC_MEM  = 2'b10;

    logic [7:0] memArr [256];

    logic [7:0] remReg, remNext;
    logic [7:0] rdmReg, rdmNext;
    logic [7:0] inBufReg, inBufNext;
    logic       inFullReg, inFullNext;
    logic [7:0] outDataReg, outDataNext;
    logic       outValidReg, outValidNext;
    logic       outOvfReg, outOvfNext;
    logic       inUnfReg, inUnfNext;

    logic       consumeIn;
    logic       acceptIn;
    logic [7:0] memRead;

    assign memRead   = memArr[remReg];
    assign consumeIn = writeRDM && (selectRDM == SRC_IN);
    assign acceptIn  = in_valid && !inFullReg;

    always_comb begin
        remNext      = remReg;
        rdmNext      = rdmReg;
        inBufNext    = inBufReg;
        inFullNext   = inFullReg;
        outDataNext  = outDataReg;
        outValidNext = outValidReg;
        outOvfNext   = outOvfReg;
        inUnfNext    = inUnfReg;

        if (writeREM) begin
            remNext = selectREM ? pc : rdmReg;
        end

        if (writeRDM) begin
            case (selectRDM)
                SRC_AC:  rdmNext = ac;
                SRC_IN:  rdmNext = inFullReg ? inBufReg : 8'h00;
                SRC_MEM: rdmNext = memRead;
                default: rdmNext = rdmReg;
            endcase
        end

        // A full buffer never accepts, so consume and accept only coincide when empty.
        if (consumeIn && inFullReg) begin
            inFullNext = 1'b0;
        end else begin
            if (consumeIn) begin
                inUnfNext = 1'b1;
            end
            if (acceptIn) begin
                inBufNext  = in_data;
                inFullNext = 1'b1;
            end
        end

        if (writeOUT) begin
            outDataNext  = rdmReg;
            outValidNext = 1'b1;
            if (outValidReg && !out_ready) begin
                outOvfNext = 1'b1;
            end
        end else if (outValidReg && out_ready) begin
            outValidNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remReg      <= 8'h00;
            rdmReg      <= 8'h00;
            inBufReg    <= 8'h00;
            inFullReg   <= 1'b0;
            outDataReg  <= 8'h00;
            outValidReg <= 1'b0;
            outOvfReg   <= 1'b0;
            inUnfReg    <= 1'b0;
        end else begin
            remReg      <= remNext;
            rdmReg      <= rdmNext;
            inBufReg    <= inBufNext;
            inFullReg   <= inFullNext;
            outDataReg  <= outDataNext;
            outValidReg <= outValidNext;
            outOvfReg   <= outOvfNext;
            inUnfReg    <= inUnfNext;
        end
    end

    // Two write ports per cycle (preload and CPU); preload wins on an address collision.
    // Memory has no reset so its contents survive rst.
    generate
        for (genvar gi = 0; gi < 256; gi++) begin : gMemWord
            always_ff @(posedge clk) begin
                if (prog_we && (prog_addr == 8'(gi))) begin
                    memArr[gi] <= prog_data;
                end else if (writeMEM && (remReg == 8'(gi))) begin
                    memArr[gi] <= rdmReg;
                end
            end
        end
    endgenerate

    assign in_ready  = !inFullReg;
    assign out_data  = outDataReg;
    assign out_valid = outValidReg;
    assign rem_q     = remReg;
    assign rdm_q     = rdmReg;
    assign mem_q     = memRead;
    assign out_ovf   = outOvfReg;
    assign in_unf    = inUnfReg;

endmodule
